id_ex_pipe_reg: RTL

- Parametrised ID/EX pipeline register; successor to the fixed-width ID/EX buffer.
- Adds a valid/ready handshake with stall hold, flush-to-bubble, NUM_OPS source operands and NUM_FWD prioritised forwarding sources.
- Forwarding hits are detected internally by register index, both at capture and while a stalled entry is held.
- Sits between decode and execute; the hazard unit drives flush, and EX/MEM/WB drive the forwarding sources.

---
 rtl/id_ex_pipe_reg.sv | 115 +++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush-to-bubble and prioritised operand forwarding.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 12,
  parameter int NUM_OPS = 2,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [31:0]               in_inst,
  input  logic [4:0]                in_rd,
  input  logic [NUM_OPS*5-1:0]      in_rs_idx,
  input  logic [NUM_OPS*XLEN-1:0]   in_rs_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*5-1:0]      fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_imm,
  output logic [2:0]                out_func3,
  output logic [6:0]                out_func7,
  output logic [4:0]                out_rd,
  output logic [NUM_OPS*XLEN-1:0]   out_rs_data
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  logic [CTRL_W-1:0]       ctrl_q;
  logic [NUM_OPS*5-1:0]    rs_idx_q;
  logic [NUM_OPS*XLEN-1:0] cap_data;
  logic [NUM_OPS*XLEN-1:0] held_data;
  logic                    load;
  logic                    hold;
  logic                    unused_inst_bits;

  assign unused_inst_bits = ^{in_inst[24:15], in_inst[11:0]};

  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;
  assign hold     = out_valid && !out_ready && !flush && !rst;
  assign out_ctrl = out_valid ? ctrl_q : '0;

  // Sources are scanned from lowest priority upward so the youngest matching stage wins.
  always_comb begin
    cap_data  = in_rs_data;
    held_data = out_rs_data;
    for (int k = 0; k < NUM_OPS; k++) begin
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (fwd_valid[j] && in_rs_idx[5*k +: 5] != 5'd0 &&
            fwd_rd[5*j +: 5] == in_rs_idx[5*k +: 5]) begin
          cap_data[XLEN*k +: XLEN] = fwd_data[XLEN*j +: XLEN];
        end
        if (fwd_valid[j] && rs_idx_q[5*k +: 5] != 5'd0 &&
            fwd_rd[5*j +: 5] == rs_idx_q[5*k +: 5]) begin
          held_data[XLEN*k +: XLEN] = fwd_data[XLEN*j +: XLEN];
        end
      end
    end
  end

  // A held entry keeps re-forwarding so producers that resolve mid-stall are still picked up.
  always_ff @(negedge clk) begin
    if (load) begin
      out_valid   <= 1'b1;
      ctrl_q      <= in_ctrl;
      out_pc      <= in_pc;
      out_imm     <= in_imm;
      out_func3   <= in_inst[14:12];
      out_func7   <= in_inst[31:25];
      out_rd      <= in_rd;
      rs_idx_q    <= in_rs_idx;
      out_rs_data <= cap_data;
    end else if (hold) begin
      out_rs_data <= held_data;
    end else begin
      out_valid   <= 1'b0;
      ctrl_q      <= '0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_func3   <= '0;
      out_func7   <= '0;
      out_rd      <= '0;
      rs_idx_q    <= '0;
      out_rs_data <= '0;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (hold)              stall_cnt  <= stall_cnt + 32'd1;
      if (!out_valid && !load) bubble_cnt <= bubble_cnt + 32'd1;
      if (flush)             flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
